// File: rtl/i2c_target_regs.sv
// I2C target exposing a NUM_REGS x 8-bit register file with an auto-incrementing pointer.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on scl/sda.
module i2c_target_regs #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h22,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_o,
  output logic                        busy_o,
  output logic                        wr_stb_o,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx_o,
  output logic [7:0]                  wr_data_o
);

  localparam int unsigned IW = $clog2(NUM_REGS);
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  // Bus synchronizers; reset to the idle-bus level so reset release looks quiet
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_s, sda_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  // Majority of three samples drops single-cycle pulses
  logic [2:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
      scl_filt_q <= (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[1] & scl_hist_q[2]) |
                    (scl_hist_q[0] & scl_hist_q[2]);
      sda_filt_q <= (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[1] & sda_hist_q[2]) |
                    (sda_hist_q[0] & sda_hist_q[2]);
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  logic scl_prev_q, sda_prev_q;
  logic scl_rise_c, scl_fall_c, start_c, stop_c;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_rise_c = scl_s & ~scl_prev_q;
  assign scl_fall_c = ~scl_s & scl_prev_q;
  assign start_c    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      tx_q, tx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            first_q, first_d;
  logic            rw_q, rw_d;
  logic            sda_q, sda_d;
  logic            busy_q, busy_d;
  logic            wr_stb_q, wr_stb_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            reg_we_c;
  logic [7:0]      regs_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      first_q   <= 1'b0;
      rw_q      <= 1'b0;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      first_q   <= first_d;
      rw_q      <= rw_d;
      sda_q     <= sda_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= 8'h00;
    end else if (reg_we_c) begin
      regs_q[ptr_q] <= shift_q;
    end
  end

  // Protocol FSM: sda_o only moves on a detected scl fall, or is released by START/STOP
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    rw_d      = rw_q;
    sda_d     = sda_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    reg_we_c  = 1'b0;

    if (start_c) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_d     = 1'b1;
      busy_d    = 1'b1;
    end else if (stop_c) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_d     = 1'b1;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (scl_rise_c) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + CW'(1);
          end else if (scl_fall_c && bit_cnt_q == CW'(8)) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              sda_d   = 1'b0;
              rw_d    = shift_q[0];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall_c) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d = RD_BYTE;
              tx_d    = regs_q[ptr_q];
              sda_d   = regs_q[ptr_q][7];
            end else begin
              state_d = WR_BYTE;
              sda_d   = 1'b1;
              first_d = 1'b1;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise_c) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + CW'(1);
          end else if (scl_fall_c && bit_cnt_q == CW'(8)) begin
            state_d = WR_ACK;
            sda_d   = 1'b0;
            if (first_q) begin
              ptr_d = shift_q[IW-1:0];
            end else begin
              reg_we_c  = 1'b1;
              wr_stb_d  = 1'b1;
              wr_idx_d  = ptr_q;
              wr_data_d = shift_q;
              ptr_d     = ptr_q + IW'(1);
            end
          end
        end
        WR_ACK: begin
          if (scl_fall_c) begin
            state_d   = WR_BYTE;
            bit_cnt_d = '0;
            first_d   = 1'b0;
            sda_d     = 1'b1;
          end
        end
        RD_BYTE: begin
          if (scl_rise_c) begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end else if (scl_fall_c) begin
            if (bit_cnt_q == CW'(8)) begin
              state_d = RD_ACK;
              sda_d   = 1'b1;
              ptr_d   = ptr_q + IW'(1);
            end else begin
              tx_d  = {tx_q[6:0], 1'b1};
              sda_d = tx_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise_c && sda_s) begin
            state_d = IGNORE;
            sda_d   = 1'b1;
          end else if (scl_fall_c) begin
            state_d   = RD_BYTE;
            bit_cnt_d = '0;
            tx_d      = regs_q[ptr_q];
            sda_d     = regs_q[ptr_q][7];
          end
        end
        default: begin
          sda_d = 1'b1;
        end
      endcase
    end
  end

  assign sda_o     = sda_q;
  assign busy_o    = busy_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_idx_o  = wr_idx_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: an I2C master model on a wired-AND sda line.
module tb_i2c_target_regs;

  localparam int Q = 8;  // clk cycles per quarter scl period

  logic       clk, rst_n, scl, sda_m;
  logic       sda_o, busy_o, wr_stb_o;
  logic [3:0] wr_idx_o;
  logic [7:0] wr_data_o;
  logic       sda_line;

  int n_checks = 0;
  int n_err    = 0;
  logic [11:0] wq[$];

  assign sda_line = sda_m & sda_o;

  i2c_target_regs #(.SLAVE_ADDR(7'h22), .NUM_REGS(16)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .scl_i    (scl),
    .sda_i    (sda_line),
    .sda_o    (sda_o),
    .busy_o   (busy_o),
    .wr_stb_o (wr_stb_o),
    .wr_idx_o (wr_idx_o),
    .wr_data_o(wr_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (wr_stb_o === 1'b1) wq.push_back({wr_idx_o, wr_data_o});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wq_(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq_(Q);
    scl = 1'b1;   wq_(Q);
    sda_m = 1'b0; wq_(Q);
    scl = 1'b0;   wq_(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq_(Q);
    scl = 1'b1;   wq_(Q);
    sda_m = 1'b1; wq_(2*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wq_(Q);
    scl = 1'b1; wq_(2*Q);
    scl = 1'b0; wq_(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wq_(Q);
    scl = 1'b1;   wq_(Q);
    ack = sda_line; wq_(Q);
    scl = 1'b0;   wq_(Q);
  endtask

  task automatic read_bit(output logic b);
    wq_(Q);
    scl = 1'b1; wq_(Q);
    b = sda_line; wq_(Q);
    scl = 1'b0; wq_(Q);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(master_ack);
    sda_m = 1'b1;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic       b;

    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    wq_(3);
    check("rst_sda", 32'(sda_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_stb", 32'(wr_stb_o), 32'd0);
    check("rst_idx", 32'(wr_idx_o), 32'd0);
    check("rst_data", 32'(wr_data_o), 32'd0);
    rst_n = 1'b1;
    wq_(4*Q);

    // Write pointer 3, then 0xA5 and 0x5A
    i2c_start();
    check("a_busy", 32'(busy_o), 32'd1);
    write_byte(8'h44, ack); check("a_ack_addr", 32'(ack), 32'd0);
    write_byte(8'h03, ack); check("a_ack_ptr", 32'(ack), 32'd0);
    write_byte(8'hA5, ack); check("a_ack_d0", 32'(ack), 32'd0);
    write_byte(8'h5A, ack); check("a_ack_d1", 32'(ack), 32'd0);
    i2c_stop();
    check("a_busy_end", 32'(busy_o), 32'd0);
    check("a_nstb", 32'(wq.size()), 32'd2);
    check("a_stb0", 32'(wq[0]), 32'h3A5);
    check("a_stb1", 32'(wq[1]), 32'h45A);
    wq.delete();

    // Pointer write, repeated START, read two bytes
    i2c_start();
    write_byte(8'h44, ack); check("b_ack_addr", 32'(ack), 32'd0);
    write_byte(8'h03, ack); check("b_ack_ptr", 32'(ack), 32'd0);
    i2c_start();
    write_byte(8'h45, ack); check("b_ack_raddr", 32'(ack), 32'd0);
    read_byte(1'b0, d); check("b_rd0", 32'(d), 32'hA5);
    read_byte(1'b1, d); check("b_rd1", 32'(d), 32'h5A);
    wq_(Q);
    check("b_sda_rel", 32'(sda_o), 32'd1);
    read_bit(b); check("b_ignored_bit", 32'(b), 32'd1);
    i2c_stop();
    check("b_nstb", 32'(wq.size()), 32'd0);

    // Foreign address is not acknowledged
    i2c_start();
    write_byte(8'h46, ack); check("c_nack", 32'(ack), 32'd1);
    check("c_busy", 32'(busy_o), 32'd1);
    write_byte(8'h55, ack); check("c_nack2", 32'(ack), 32'd1);
    i2c_stop();
    check("c_busy_end", 32'(busy_o), 32'd0);
    check("c_nstb", 32'(wq.size()), 32'd0);

    // Pointer wraps from 15 to 0
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h0F, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack); check("d_ack", 32'(ack), 32'd0);
    i2c_stop();
    check("d_nstb", 32'(wq.size()), 32'd2);
    check("d_stb0", 32'(wq[0]), 32'hF11);
    check("d_stb1", 32'(wq[1]), 32'h022);
    wq.delete();

    // Reset in the middle of reading reg 0 (0x22)
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h00, ack);
    i2c_stop();
    i2c_start();
    write_byte(8'h45, ack); check("e_ack", 32'(ack), 32'd0);
    sda_m = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    check("e_first4", 32'(d[3:0]), 32'h2);
    wq_(Q);
    scl = 1'b1; wq_(Q);
    check("e_bit5_low", 32'(sda_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("e_rst_sda", 32'(sda_o), 32'd1);
    check("e_rst_busy", 32'(busy_o), 32'd0);
    wq_(Q);
    rst_n = 1'b1;
    wq_(4*Q);
    check("e_idle_busy", 32'(busy_o), 32'd0);
    i2c_start();
    write_byte(8'h45, ack); check("e_ack2", 32'(ack), 32'd0);
    read_byte(1'b1, d); check("e_rd_reg0", 32'(d), 32'h00);
    i2c_stop();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // Single-cycle sda dip with scl high must not look like START
    sda_m = 1'b0; wq_(1);
    sda_m = 1'b1; wq_(4*Q);
    check("g_busy", 32'(busy_o), 32'd0);
    check("g_sda", 32'(sda_o), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
